dfc_gen: RTL and testbench
==========================

DFC_GEN -- requirements
Module: dfc_gen

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the input sample width in bits (legal: 2..16).
REQ-002 Parameter DEPTH, default 8, SHALL set the number of buffer entries (legal: even, power of two, 2..64); PAIRS = DEPTH/2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-005 datain  input  DATA_W  SHALL carry load samples.
REQ-006 cmd  input  2  SHALL select the operation: 0 load, 1 FIFO-order sum out, 2 LIFO-order sum out, 3 difference out.
REQ-007 cmd_valid  input  1  SHALL qualify cmd.
REQ-008 dataout  output  DATA_W+1  SHALL carry result words.
REQ-009 output_valid  output  1  SHALL be high only in cycles where dataout carries a result.
REQ-010 out_last  output  1  SHALL be high with the final result word of a command.
REQ-011 busy  output  1  SHALL be high whenever the block is not in IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, OUT_FWD, OUT_REV; busy SHALL be decoded combinationally from state.
REQ-013 In IDLE, cmd_valid=1 SHALL accept cmd on that edge; cmd_valid while busy=1 SHALL be ignored with no side effect.
REQ-014 cmd 0: IDLE->LOAD; datain in cycle accept+1+i SHALL be written to buf[i], i=0..DEPTH-1; after the edge ending cycle accept+DEPTH, IDLE.
REQ-015 Sum word k SHALL be buf[k]+buf[k+PAIRS], zero-extended to DATA_W+1 bits, no overflow loss.
REQ-016 cmd 1: IDLE->OUT_FWD; words k=0..PAIRS-1 SHALL appear on dataout in cycles accept+1+k, output_valid=1, then IDLE.
REQ-017 cmd 2: IDLE->OUT_REV; words SHALL appear in order k=PAIRS-1..0 with the same timing as REQ-016.
REQ-018 dataout/output_valid/out_last SHALL be registered, loaded on the accepting edge, so output_valid is high exactly in the PAIRS cycles busy is high.
REQ-019 When output_valid=0, dataout SHALL be 0 and out_last 0.
REQ-020 A new command SHALL be acceptable in the first IDLE cycle after completion (zero-gap back-to-back).
REQ-021 Output commands SHALL read the buffer contents as they stand; output commands SHALL NOT modify the buffer.
REQ-022 An output command issued before any load SHALL produce all-zero words.
REQ-023 Internal element/word counters SHALL be sized ceil(log2(DEPTH)) and SHALL NOT wrap within a command.

Reset
REQ-024 reset=0 at a clock edge SHALL force state IDLE, all buf entries 0, counters 0, dataout 0, output_valid 0, out_last 0.
REQ-025 Reset mid-LOAD or mid-output SHALL abort the command; partially written entries SHALL be cleared; busy SHALL be 0 in the cycle after the reset edge.
REQ-026 reset SHALL take priority over cmd_valid on the same edge.

Configuration
REQ-027 With macro DFC_GEN_DIFF_EN defined, cmd 3 SHALL enter OUT_FWD emitting buf[k]-buf[k+PAIRS] as DATA_W+1-bit two's complement, k ascending, timing per REQ-016.
REQ-028 Without DFC_GEN_DIFF_EN, cmd 3 with cmd_valid SHALL be ignored: state stays IDLE, busy 0, no output, buffer unchanged.

Verification (DATA_W=8, DEPTH=8)
REQ-029 Load 1,2,..,8 then cmd 1 -> dataout 6,8,10,12 in 4 consecutive valid cycles, out_last with 12, busy high exactly those 4 cycles.
REQ-030 Same load then cmd 2 -> 12,10,8,6, out_last with 6.
REQ-031 Load all 8'hFF then cmd 1 -> four words 9'h1FE.
REQ-032 Load 1..8, cmd 3 with DFC_GEN_DIFF_EN -> four words 9'h1FC; without macro -> busy stays 0, output_valid stays 0.
REQ-033 Drive reset=0 during 4th load sample, release, then cmd 1 -> four words 9'h000.
REQ-034 Pulse cmd_valid with cmd 0 during an OUT_FWD sequence -> ignored, output sequence unchanged; cmd 2 issued in first IDLE cycle after -> accepted with zero gap.

Source files
------------

// File: rtl/dfc_gen.sv
// Buffered pair-sum generator: loads DEPTH samples, then emits buf[k]+buf[k+PAIRS] in forward or reverse order.
// Optional macro DFC_GEN_DIFF_EN enables cmd 3 (pair differences, two's complement).
module dfc_gen #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] datain,
    input  logic [1:0]        cmd,
    input  logic              cmd_valid,
    output logic [DATA_W:0]   dataout,
    output logic              output_valid,
    output logic              out_last,
    output logic              busy
);

    localparam int PAIRS = DEPTH / 2;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_W = AW'(PAIRS - 1);
    localparam logic [AW-1:0] LAST_E = AW'(DEPTH - 1);
    localparam logic [AW-1:0] HALF   = AW'(PAIRS);

`ifdef DFC_GEN_DIFF_EN
    localparam bit DIFF_EN = 1'b1;
`else
    localparam bit DIFF_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, OUT_FWD, OUT_REV} state_t;

    state_t              state, next_state;
    logic [AW-1:0]       cnt, nidx;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                diff_mode, use_diff, nlast, start_out;
    logic [DATA_W:0]     nword;

    function automatic logic [DATA_W:0] sum_word(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [DATA_W:0] diff_word(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic signed [DATA_W:0] sa, sb;
        sa = $signed({1'b0, a});
        sb = $signed({1'b0, b});
        return sa - sb;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd)
                        2'd0:    next_state = LOAD;
                        2'd1:    next_state = OUT_FWD;
                        2'd2:    next_state = OUT_REV;
                        default: if (DIFF_EN) next_state = OUT_FWD;
                    endcase
                end
            end
            LOAD:    if (cnt == LAST_E) next_state = IDLE;
            OUT_FWD: if (cnt == LAST_W) next_state = IDLE;
            OUT_REV: if (cnt == '0)     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Index and value of the word to present after the coming edge
    always_comb begin
        nidx     = '0;
        use_diff = diff_mode;
        case (state)
            IDLE: begin
                nidx     = (cmd == 2'd2) ? LAST_W : '0;
                use_diff = DIFF_EN && (cmd == 2'd3);
            end
            OUT_FWD: nidx = cnt + 1'b1;
            OUT_REV: nidx = cnt - 1'b1;
            default: nidx = '0;
        endcase
        if (state == OUT_REV || (state == IDLE && cmd == 2'd2))
            nlast = (nidx == '0);
        else
            nlast = (nidx == LAST_W);
        nword = use_diff ? diff_word(mem[nidx], mem[nidx | HALF])
                         : sum_word(mem[nidx], mem[nidx | HALF]);
        start_out = (state == IDLE) && (next_state == OUT_FWD || next_state == OUT_REV);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt          <= '0;
            diff_mode    <= 1'b0;
            dataout      <= '0;
            output_valid <= 1'b0;
            out_last     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_out) begin
                        cnt          <= nidx;
                        diff_mode    <= use_diff;
                        dataout      <= nword;
                        output_valid <= 1'b1;
                        out_last     <= nlast;
                    end else begin
                        cnt <= '0;
                    end
                end
                LOAD: begin
                    mem[cnt] <= datain;
                    cnt      <= (cnt == LAST_E) ? '0 : cnt + 1'b1;
                end
                OUT_FWD, OUT_REV: begin
                    if (next_state == IDLE) begin
                        cnt          <= '0;
                        dataout      <= '0;
                        output_valid <= 1'b0;
                        out_last     <= 1'b0;
                    end else begin
                        cnt      <= nidx;
                        dataout  <= nword;
                        out_last <= nlast;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dfc_gen.sv
// Directed self-checking bench for dfc_gen (DATA_W=8, DEPTH=8).
module tb_dfc_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] datain = '0;
    logic [1:0] cmd = '0;
    logic       cmd_valid = 1'b0;
    logic [8:0] dataout;
    logic       output_valid, out_last, busy;

    int pass_cnt = 0;
    int total    = 0;
    logic [11:0] cap [5];   // {busy, output_valid, out_last, dataout}

    always #5 clk = ~clk;

    dfc_gen #(.DATA_W(8), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .datain(datain), .cmd(cmd), .cmd_valid(cmd_valid),
        .dataout(dataout), .output_valid(output_valid), .out_last(out_last), .busy(busy)
    );

    function automatic logic [11:0] ev(input logic last, input logic [8:0] d);
        return {2'b11, last, d};
    endfunction

    task automatic start_cmd(input logic [1:0] c);
        @(negedge clk); cmd = c; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
    endtask

    task automatic capture();
        for (int k = 0; k < 5; k++) begin
            cap[k] = {busy, output_valid, out_last, dataout};
            if (k < 4) @(negedge clk);
        end
    endtask

    task automatic do_load(input int mode);
        @(negedge clk); cmd = 2'd0; cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); cmd_valid = 1'b0;
            datain = (mode != 0) ? 8'hFF : 8'(i + 1);
        end
        @(negedge clk); datain = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0; cmd = 2'd1; cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, output_valid, out_last, dataout} !== 12'h000) begin
            $display("FAIL reset_state: got %h want %h", {busy, output_valid, out_last, dataout}, 12'h000);
        end else pass_cnt++;
        cmd_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_no_load();
        start_cmd(2'd1);
        capture();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[k] !== ev(k == 3, 9'h000)) $display("FAIL no_load_w%0d: got %h want %h", k, cap[k], ev(k == 3, 9'h000));
            else pass_cnt++;
        end
    endtask

    task automatic test_fwd();
        logic [8:0] exp_w [4] = '{9'd6, 9'd8, 9'd10, 9'd12};
        do_load(0);
        total++;
        if (busy !== 1'b0) $display("FAIL load_done_busy: got %b want 0", busy);
        else pass_cnt++;
        start_cmd(2'd1);
        capture();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[k] !== ev(k == 3, exp_w[k])) $display("FAIL fwd_w%0d: got %h want %h", k, cap[k], ev(k == 3, exp_w[k]));
            else pass_cnt++;
        end
        total++;
        if (cap[4] !== 12'h000) $display("FAIL fwd_after: got %h want %h", cap[4], 12'h000);
        else pass_cnt++;
    endtask

    task automatic test_rev();
        logic [8:0] exp_w [4] = '{9'd12, 9'd10, 9'd8, 9'd6};
        start_cmd(2'd2);
        capture();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[k] !== ev(k == 3, exp_w[k])) $display("FAIL rev_w%0d: got %h want %h", k, cap[k], ev(k == 3, exp_w[k]));
            else pass_cnt++;
        end
        total++;
        if (cap[4] !== 12'h000) $display("FAIL rev_after: got %h want %h", cap[4], 12'h000);
        else pass_cnt++;
    endtask

    task automatic test_all_ff();
        do_load(1);
        start_cmd(2'd1);
        capture();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[k] !== ev(k == 3, 9'h1FE)) $display("FAIL ff_w%0d: got %h want %h", k, cap[k], ev(k == 3, 9'h1FE));
            else pass_cnt++;
        end
    endtask

    task automatic test_cmd3();
        logic [8:0] exp_w [4] = '{9'd6, 9'd8, 9'd10, 9'd12};
        do_load(0);
        start_cmd(2'd3);
        capture();
`ifdef DFC_GEN_DIFF_EN
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[k] !== ev(k == 3, 9'h1FC)) $display("FAIL diff_w%0d: got %h want %h", k, cap[k], ev(k == 3, 9'h1FC));
            else pass_cnt++;
        end
`else
        for (int k = 0; k < 5; k++) begin
            total++;
            if (cap[k] !== 12'h000) $display("FAIL cmd3_ignored_c%0d: got %h want %h", k, cap[k], 12'h000);
            else pass_cnt++;
        end
`endif
        start_cmd(2'd1);
        capture();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[k] !== ev(k == 3, exp_w[k])) $display("FAIL post_cmd3_w%0d: got %h want %h", k, cap[k], ev(k == 3, exp_w[k]));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midload();
        @(negedge clk); cmd = 2'd0; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0; datain = 8'd1;
        @(negedge clk); datain = 8'd2;
        @(negedge clk); datain = 8'd3;
        @(negedge clk); datain = 8'd4; reset = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, output_valid} !== 2'b00) $display("FAIL midload_reset_busy: got %b want 00", {busy, output_valid});
        else pass_cnt++;
        reset = 1'b1; datain = '0;
        start_cmd(2'd1);
        capture();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[k] !== ev(k == 3, 9'h000)) $display("FAIL midload_w%0d: got %h want %h", k, cap[k], ev(k == 3, 9'h000));
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] fwd_w [4] = '{9'd6, 9'd8, 9'd10, 9'd12};
        logic [8:0] rev_w [4] = '{9'd12, 9'd10, 9'd8, 9'd6};
        logic [11:0] obs;
        do_load(0);
        @(negedge clk); cmd = 2'd1; cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            obs = {busy, output_valid, out_last, dataout};
            cmd_valid = 1'b0;
            if (k == 1) begin cmd = 2'd0; cmd_valid = 1'b1; end
            if (k == 3) cmd = 2'd2;
            total++;
            if (obs !== ev(k == 3, fwd_w[k])) $display("FAIL b2b_fwd_w%0d: got %h want %h", k, obs, ev(k == 3, fwd_w[k]));
            else pass_cnt++;
        end
        @(negedge clk);
        obs = {busy, output_valid, out_last, dataout};
        cmd = 2'd2; cmd_valid = 1'b1;
        total++;
        if (obs !== 12'h000) $display("FAIL b2b_gap: got %h want %h", obs, 12'h000);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            obs = {busy, output_valid, out_last, dataout};
            total++;
            if (obs !== ev(k == 3, rev_w[k])) $display("FAIL b2b_rev_w%0d: got %h want %h", k, obs, ev(k == 3, rev_w[k]));
            else pass_cnt++;
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL b2b_end_busy: got %b want 0", busy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_no_load();
        test_fwd();
        test_rev();
        test_all_ff();
        test_cmd3();
        test_reset_midload();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
